// File: rtl/latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : latch_write_arbiter
//  Purpose  : Shares one WIDTH-bit gate-level D-latch register between four
//             clocked requesters. Arbitrates round-robin, then drives the
//             latch data and shared gate through a fixed setup / open / hold
//             sequence so the latch's gate-delay timing is met by construction,
//             and finally pulses a one-hot acknowledge to the winner.
//  Optional : LATCH_WR_VERIFY_EN adds a latch_q readback input, an err output
//             and a one-cycle VERIFY state between HOLD and ACK.
//  Ports    :
//    clk       in   1        clock, rising edge
//    rst       in   1        synchronous active-high reset
//    req       in   4        per-requester write request (level)
//    wdata     in   4*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//    ack       out  4        one-hot one-cycle completion pulse
//    grant_id  out  2        index of current / last granted requester
//    busy      out  1        high in every state except IDLE
//    latch_d   out  WIDTH    data to latch bank d inputs
//    latch_c   out  1        shared gate to latch bank c input
//    latch_q   in   WIDTH    latch bank q outputs   (LATCH_WR_VERIFY_EN only)
//    err       out  1        readback mismatch flag (LATCH_WR_VERIFY_EN only)
//  Revision : 1.0  initial release
// ============================================================================
module latch_write_arbiter #(
   parameter int WIDTH        = 8,
   parameter int SETUP_CYCLES = 1,
   parameter int OPEN_CYCLES  = 2,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] wdata,
   output logic [3:0]         ack,
   output logic [1:0]         grant_id,
   output logic               busy,
   output logic [WIDTH-1:0]   latch_d,
   output logic               latch_c
`ifdef LATCH_WR_VERIFY_EN
   ,
   input  logic [WIDTH-1:0]   latch_q,
   output logic               err
`endif
);

   // Counters hold (cycles - 1) of the longest phase.
   localparam int MAX_CYC = (SETUP_CYCLES > OPEN_CYCLES)
                            ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                            : ((OPEN_CYCLES  > HOLD_CYCLES) ? OPEN_CYCLES  : HOLD_CYCLES);
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_CYCLES  - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES  - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_OPEN   = 3'd2,
      S_HOLD   = 3'd3,
      S_VERIFY = 3'd4,
      S_ACK    = 3'd5
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       rr_ptr;

   logic             pick_valid;
   logic [1:0]       pick_id;
   logic [1:0]       cand;
   logic [WIDTH-1:0] pick_data;

   // Round-robin pick: scan from rr_ptr upwards (wrapping). Iterating from
   // the farthest candidate down lets the nearest requester overwrite last.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = rr_ptr;
      cand       = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         cand = rr_ptr + 2'(k);
         if (req[cand]) begin
            pick_valid = 1'b1;
            pick_id    = cand;
         end
      end
   end

   assign pick_data = wdata[pick_id*WIDTH +: WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         // Gate and data drop together; an in-flight write is abandoned.
         state    <= S_IDLE;
         cnt      <= '0;
         rr_ptr   <= 2'd0;
         grant_id <= 2'd0;
         latch_d  <= '0;
         latch_c  <= 1'b0;
         ack      <= 4'b0000;
         busy     <= 1'b0;
`ifdef LATCH_WR_VERIFY_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  // latch_d is written only here, so it stays constant
                  // through the whole sequence and until the next grant.
                  latch_d  <= pick_data;
                  grant_id <= pick_id;
                  rr_ptr   <= pick_id + 2'd1;
                  busy     <= 1'b1;
                  cnt      <= SETUP_LOAD;
                  state    <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (cnt == '0) begin
                  latch_c <= 1'b1;
                  cnt     <= OPEN_LOAD;
                  state   <= S_OPEN;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_OPEN: begin
               if (cnt == '0) begin
                  latch_c <= 1'b0;
                  cnt     <= HOLD_LOAD;
                  state   <= S_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_HOLD: begin
               if (cnt == '0) begin
                  cnt   <= '0;
`ifdef LATCH_WR_VERIFY_EN
                  state <= S_VERIFY;
`else
                  ack   <= 4'b0001 << grant_id;
                  state <= S_ACK;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

`ifdef LATCH_WR_VERIFY_EN
            S_VERIFY: begin
               // Readback result is registered so it lines up with ack.
               err   <= (latch_q != latch_d);
               ack   <= 4'b0001 << grant_id;
               state <= S_ACK;
            end
`endif

            S_ACK: begin
               ack   <= 4'b0000;
               busy  <= 1'b0;
`ifdef LATCH_WR_VERIFY_EN
               err   <= 1'b0;
`endif
               state <= S_IDLE;
            end

            default: begin
               latch_c <= 1'b0;
               ack     <= 4'b0000;
               busy    <= 1'b0;
               cnt     <= '0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_latch_write_arbiter
//  Purpose  : Self-checking bench for latch_write_arbiter. Directed steps
//             followed by random request traffic, checked against a
//             transaction-level round-robin / timing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_latch_write_arbiter;

   localparam int W = 8;
   localparam int S = 1;
   localparam int O = 2;
   localparam int H = 1;
`ifdef LATCH_WR_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif
   localparam int LAT = S + O + H + VER;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     req;
   logic [4*W-1:0] wdata;
   logic [3:0]     ack;
   logic [1:0]     grant_id;
   logic           busy;
   logic [W-1:0]   latch_d;
   logic           latch_c;
   logic           q_zero = 1'b0;
`ifdef LATCH_WR_VERIFY_EN
   logic [W-1:0]   latch_q;
   logic           err;
   assign latch_q = q_zero ? '0 : latch_d;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [1:0] ptr;

   always #5 clk = ~clk;

   latch_write_arbiter #(
      .WIDTH(W), .SETUP_CYCLES(S), .OPEN_CYCLES(O), .HOLD_CYCLES(H)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata),
      .ack(ack), .grant_id(grant_id), .busy(busy),
      .latch_d(latch_d), .latch_c(latch_c)
`ifdef LATCH_WR_VERIFY_EN
      , .latch_q(latch_q), .err(err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First requester at or after p in cyclic order.
   function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (int'(p) + k) % 4;
         if (r[i]) return 2'(i);
      end
      return p;
   endfunction

   // One full transaction starting with the DUT in IDLE and req != 0.
   task automatic txn(input logic keep, input logic [3:0] late_mask, input int late_t,
                      input logic scramble, input logic [W-1:0] new_val);
      logic [1:0]   w;
      logic [W-1:0] d;
      w = rr_pick(ptr, req);
      d = wdata[w*W +: W];
      tick();
      chk("grant_id", 32'(grant_id), 32'(w));
      chk("latch_d_at_grant", 32'(latch_d), 32'(d));
      chk("busy_at_grant", 32'(busy), 32'd1);
      chk("latch_c_at_grant", 32'(latch_c), 32'd0);
      chk("ack_at_grant", 32'(ack), 32'd0);
      ptr = w + 2'd1;
      if (scramble) wdata[w*W +: W] = new_val;
      for (int t = 1; t <= LAT; t++) begin
         if (t == late_t) req = req | late_mask;
         tick();
         chk("latch_c_seq", 32'(latch_c), (t >= S && t < S + O) ? 32'd1 : 32'd0);
         chk("latch_d_stable", 32'(latch_d), 32'(d));
         chk("busy_seq", 32'(busy), 32'd1);
         chk("ack_seq", 32'(ack), (t == LAT) ? 32'(4'b0001 << w) : 32'd0);
`ifdef LATCH_WR_VERIFY_EN
         chk("err_seq", 32'(err), (t == LAT && q_zero && d != '0) ? 32'd1 : 32'd0);
`endif
      end
      if (!keep) req[w] = 1'b0;
      tick();
      chk("ack_after", 32'(ack), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("latch_c_after", 32'(latch_c), 32'd0);
      chk("latch_d_after", 32'(latch_d), 32'(d));
`ifdef LATCH_WR_VERIFY_EN
      chk("err_after", 32'(err), 32'd0);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_latch_d", 32'(latch_d), 32'd0);
      chk("rst_latch_c", 32'(latch_c), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef LATCH_WR_VERIFY_EN
      chk("rst_err", 32'(err), 32'd0);
`endif
      rst = 1'b0;
      ptr = 2'd0;
   endtask

   initial begin
      rst   = 1'b1;
      req   = 4'b0000;
      wdata = '0;
      ptr   = 2'd0;

      // Reset state, then a single write from requester 0.
      do_reset();
      wdata[0*W +: W] = 8'hA5;
      req = 4'b0001;
      txn(1'b0, 4'b0000, 0, 1'b0, 8'h00);

      // All four held: grants 0,1,2,3,0 from a fresh pointer.
      do_reset();
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      for (int n = 0; n < 5; n++) txn(1'b1, 4'b0000, 0, 1'b0, 8'h00);
      req = 4'b0000;
      tick();

      // req1 held; req3 arrives during OPEN -> 1, then 3, then 1.
      req = 4'b0010;
      txn(1'b1, 4'b1000, S + 1, 1'b0, 8'h00);
      txn(1'b0, 4'b0000, 0, 1'b0, 8'h00);
      txn(1'b0, 4'b0000, 0, 1'b0, 8'h00);

      // wdata change during SETUP is ignored.
      wdata[0*W +: W] = 8'h5A;
      req = 4'b0001;
      txn(1'b0, 4'b0000, 0, 1'b1, 8'hC3);

      // Reset in the second OPEN cycle abandons the write.
      req = 4'b0100;
      tick();
      for (int t = 1; t <= S + 1; t++) tick();
      chk("open_before_rst", 32'(latch_c), 32'd1);
      rst = 1'b1;
      req = 4'b0000;
      tick();
      chk("abort_latch_c", 32'(latch_c), 32'd0);
      chk("abort_latch_d", 32'(latch_d), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ack", 32'(ack), 32'd0);
      rst = 1'b0;
      ptr = 2'd0;
      tick();
      chk("abort_no_ack", 32'(ack), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      wdata[2*W +: W] = 8'h96;
      req = 4'b0100;
      txn(1'b0, 4'b0000, 0, 1'b0, 8'h00);

`ifdef LATCH_WR_VERIFY_EN
      // Readback mismatch: latch_q forced to zero with data 0xFF.
      q_zero = 1'b1;
      wdata[1*W +: W] = 8'hFF;
      req = 4'b0010;
      txn(1'b0, 4'b0000, 0, 1'b0, 8'h00);
      q_zero = 1'b0;
`endif

      // Random traffic: requests accumulate until served.
      for (int n = 0; n < 40; n++) begin
         req = req | 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) wdata[i*W +: W] = 8'($urandom);
         if (req == 4'b0000) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ack", 32'(ack), 32'd0);
         end else begin
            txn(1'b0, 4'b0000, 0, 1'($urandom_range(0, 1)), 8'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Synchronous controller that shares one WIDTH-bit gate-level D-latch register between four requesters. It arbitrates round-robin and drives the latch data and gate with a fixed setup / open / hold sequence, so the latch's gate-delay timing is met by construction. It then acknowledges the winning requester. It sits between clocked lab logic and a latch bank built from nand-gate D latches with one shared gate.

## Interface
Parameters:
- WIDTH, 8, data width of the latch register
- SETUP_CYCLES, 1, cycles latch_d is stable before latch_c rises (min 1)
- OPEN_CYCLES, 2, cycles latch_c is held high (min 1)
- HOLD_CYCLES, 1, cycles latch_d is held after latch_c falls (min 1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  per-requester write request, level, held until ack
- wdata  in  4*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- ack  out  4  one-hot, one-cycle completion pulse to the granted requester
- grant_id  out  2  index of current/last granted requester
- busy  out  1  high in every state except IDLE
- latch_d  out  WIDTH  data to latch bank d inputs
- latch_c  out  1  gate to latch bank c input
- latch_q  in  WIDTH  latch bank q outputs (only with LATCH_WR_VERIFY_EN)
- err  out  1  readback mismatch pulse (only with LATCH_WR_VERIFY_EN)

## Operation
- States: IDLE, SETUP, OPEN, HOLD, [VERIFY], ACK.
- IDLE: if any req bit is set, grant the first requester at or after rr_ptr (cyclic order 0→1→2→3→0). Register its wdata into latch_d, set grant_id, set rr_ptr = grant+1 mod 4, and go to SETUP. Otherwise stay in IDLE.
- SETUP: count SETUP_CYCLES, then go to OPEN. OPEN: latch_c=1, count OPEN_CYCLES, then go to HOLD. HOLD: latch_c=0, count HOLD_CYCLES, then go to VERIFY (macro on) or ACK.
- VERIFY: one cycle. Compare latch_q to latch_d and register the result into err, asserted in ACK. Then go to ACK.
- ACK: ack[grant_id]=1 for exactly one cycle, then go to IDLE. No arbitration is done in ACK.
- latch_d is written only on the IDLE→SETUP transition. It is constant from then until the next grant, including during ACK and IDLE.
- latch_c is 1 only in OPEN.
- Requester contract: drop req no later than the cycle after ack is seen. A req still high when IDLE samples it is treated as a new request.
- Changes to wdata after grant are ignored. A requester whose req drops before grant is simply not served.
- Reset values: state=IDLE, latch_c=0, latch_d=0, ack=0, grant_id=0, busy=0, err=0, rr_ptr=0, counters=0.

## Timing
- Grant edge G is the IDLE edge with req≠0. latch_d is valid from G.
- latch_c rises at G+SETUP_CYCLES and falls at G+SETUP_CYCLES+OPEN_CYCLES.
- Macro off: ack rises at G+S+O+H and lasts 1 cycle. Macro on: G+S+O+H+1.
- With defaults and macro off, the transaction is 5 cycles grant-to-IDLE. The earliest next grant is the edge ending the first IDLE cycle after ACK.
- Simultaneous requests: one grant per transaction. With rr_ptr=0 and all four req held, grants come in the order 0,1,2,3,0,…
- Reset in any state takes effect at that edge: latch_c=0 and latch_d=0 together. The in-flight write is abandoned, no ack is issued, and the latch contents are undefined. This is the only case where hold timing is not guaranteed.
- Counters are sized for the largest of the three parameters and reload on each state entry.

## Configuration
- LATCH_WR_VERIFY_EN defined: the latch_q input, err output and VERIFY state exist. err=1 in the ACK cycle iff latch_q≠latch_d at VERIFY, and 0 otherwise.
- LATCH_WR_VERIFY_EN undefined: latch_q and err ports are absent, HOLD goes directly to ACK, and latency is one cycle shorter.

## Test plan
- Reset, then req=0001 with wdata0=0xA5. Expect: latch_d=0xA5 at G, latch_c high for exactly 2 cycles starting G+1, ack=0001 at G+4 for one cycle, busy low afterwards.
- req=1111 held with distinct data 0x11/0x22/0x33/0x44. Expect: ack order 0,1,2,3,0; grant_id matches each ack; latch_d never changes while latch_c=1.
- req1 granted and held; req3 arrives during OPEN. Expect: req1 completes, next grant=3 (rr_ptr=2), then 1.
- rst asserted during the second OPEN cycle. Expect: next cycle latch_c=0, latch_d=0, busy=0, no ack. After rst release, req=0100 is served normally with grant_id=2.
- Macro on, latch_q tied to latch_d. Expect: err=0 with ack. Then force latch_q=0x00 with data 0xFF. Expect: err=1 in the ACK cycle only.
- wdata0 changes 0x5A→0xC3 during SETUP. Expect: latch_d stays 0x5A through ACK.
